// File: rtl/fu_sched_pkg.sv
// Shared opcode constants, FSM encoding and round-robin search for fu_sched.
// FU_SCHED_MULT_2CYC_EN adds the MUL state to the encoding.
package fu_sched_pkg;

  localparam int unsigned FU      = 4;
  localparam int unsigned MAX_REQ = 8;

  localparam logic [FU-1:0] OP_ADD  = 4'd0;
  localparam logic [FU-1:0] OP_SUB  = 4'd1;
  localparam logic [FU-1:0] OP_MULT = 4'd2;
  localparam logic [FU-1:0] OP_SLL  = 4'd3;
  localparam logic [FU-1:0] OP_SRL  = 4'd4;
  localparam logic [FU-1:0] OP_AND  = 4'd5;
  localparam logic [FU-1:0] OP_OR   = 4'd6;
  localparam logic [FU-1:0] OP_NOT  = 4'd7;
  localparam logic [FU-1:0] OP_XOR  = 4'd8;

`ifdef FU_SCHED_MULT_2CYC_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StFull = 2'd1, StMul = 2'd2} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StFull = 2'd1} state_e;
`endif

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_grant_t;

  // First valid index at or above ptr, wrapping modulo n (n <= MAX_REQ).
  function automatic rr_grant_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                        input logic [2:0]         ptr,
                                        input int unsigned        n);
    rr_grant_t   g;
    int unsigned idx;
    g = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if ((k < n) && !g.found && valid[idx[2:0]]) begin
        g.found = 1'b1;
        g.idx   = idx[2:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/fu_sched_fu.sv
// Shared combinational functional unit: 32-bit wrap-around ALU, unknown opcodes give 0.
module fu_sched_fu
  import fu_sched_pkg::*;
(
  input  logic [31:0]   i_a,
  input  logic [31:0]   i_b,
  input  logic [FU-1:0] i_op,
  output logic [31:0]   o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_MULT: o_y = i_a * i_b;
      // Shift amount is the whole of b, so anything >= 32 clears the result.
      OP_SLL:  o_y = (i_b > 32'd31) ? '0 : (i_a << i_b[4:0]);
      OP_SRL:  o_y = (i_b > 32'd31) ? '0 : (i_a >> i_b[4:0]);
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_NOT:  o_y = ~i_a;
      OP_XOR:  o_y = i_a ^ i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/fu_sched.sv
// Round-robin scheduler sharing one fu among N_REQ requesters, one-entry result buffer.
// FU_SCHED_MULT_2CYC_EN makes MULT take two cycles through a MUL state.
module fu_sched
  import fu_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  input  logic [N_REQ*FU-1:0] req_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic [ID_W-1:0]     rsp_id,
  output logic                busy
);

  state_e            r_state, w_state_next;
  logic [31:0]       r_rsp_data, w_rsp_data_next;
  logic [ID_W-1:0]   r_rsp_id, w_rsp_id_next;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_next;

  logic [MAX_REQ-1:0] w_valid_ext;
  rr_grant_t          w_grant;
  logic [ID_W-1:0]    w_gid;
  logic               w_can_accept;
  logic               w_accept;
  logic [31:0]        w_g_a, w_g_b;
  logic [FU-1:0]      w_g_op;
  logic [31:0]        w_fu_a, w_fu_b, w_fu_y;
  logic [FU-1:0]      w_fu_op;

`ifdef FU_SCHED_MULT_2CYC_EN
  logic [31:0]     r_mul_a, r_mul_b, w_mul_a_next, w_mul_b_next;
  logic [ID_W-1:0] r_mul_id, w_mul_id_next;
`endif

  assign w_valid_ext  = MAX_REQ'(req_valid);
  assign w_grant      = rr_pick(w_valid_ext, 3'(r_rr_ptr), N_REQ);
  assign w_gid        = ID_W'(w_grant.idx);
  assign w_can_accept = (r_state == StIdle) || ((r_state == StFull) && rsp_ready);
  assign w_accept     = w_can_accept && w_grant.found;

  assign w_g_a  = req_a[32'(w_gid) * 32 +: 32];
  assign w_g_b  = req_b[32'(w_gid) * 32 +: 32];
  assign w_g_op = req_op[32'(w_gid) * FU +: FU];

  // Gated by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    req_ready = '0;
    if (w_accept && rst_n) begin
      req_ready[w_gid] = 1'b1;
    end
  end

  always_comb begin
    w_fu_a  = w_g_a;
    w_fu_b  = w_g_b;
    w_fu_op = w_g_op;
`ifdef FU_SCHED_MULT_2CYC_EN
    if (r_state == StMul) begin
      w_fu_a  = r_mul_a;
      w_fu_b  = r_mul_b;
      w_fu_op = OP_MULT;
    end
`endif
  end

  fu_sched_fu u_fu (
    .i_a  (w_fu_a),
    .i_b  (w_fu_b),
    .i_op (w_fu_op),
    .o_y  (w_fu_y)
  );

  always_comb begin
    w_state_next    = r_state;
    w_rsp_data_next = r_rsp_data;
    w_rsp_id_next   = r_rsp_id;
    w_rr_ptr_next   = r_rr_ptr;
`ifdef FU_SCHED_MULT_2CYC_EN
    w_mul_a_next    = r_mul_a;
    w_mul_b_next    = r_mul_b;
    w_mul_id_next   = r_mul_id;
`endif
    case (r_state)
      StIdle, StFull: begin
        if (w_accept) begin
          w_rr_ptr_next = (w_gid == ID_W'(N_REQ - 1)) ? '0 : w_gid + 1'b1;
`ifdef FU_SCHED_MULT_2CYC_EN
          if (w_g_op == OP_MULT) begin
            w_state_next  = StMul;
            w_mul_a_next  = w_g_a;
            w_mul_b_next  = w_g_b;
            w_mul_id_next = w_gid;
          end else
`endif
          begin
            w_state_next    = StFull;
            w_rsp_data_next = w_fu_y;
            w_rsp_id_next   = w_gid;
          end
        end else if ((r_state == StFull) && rsp_ready) begin
          w_state_next = StIdle;
        end
      end
`ifdef FU_SCHED_MULT_2CYC_EN
      StMul: begin
        w_state_next    = StFull;
        w_rsp_data_next = w_fu_y;
        w_rsp_id_next   = r_mul_id;
      end
`endif
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
      r_rr_ptr   <= '0;
`ifdef FU_SCHED_MULT_2CYC_EN
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_id   <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_rsp_data <= w_rsp_data_next;
      r_rsp_id   <= w_rsp_id_next;
      r_rr_ptr   <= w_rr_ptr_next;
`ifdef FU_SCHED_MULT_2CYC_EN
      r_mul_a    <= w_mul_a_next;
      r_mul_b    <= w_mul_b_next;
      r_mul_id   <= w_mul_id_next;
`endif
    end
  end

  assign rsp_valid = (r_state == StFull);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_fu_sched.sv
// Self-checking bench for fu_sched: vector table plus hand-written handshake sequences.
module tb_fu_sched;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N*4-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [31:0]    rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;

  fu_sched #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  id;
  } exp_t;

  vec_t tbl[14];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_op[r*4 +: 4]  = op;
  endtask

  // Waits a bounded number of edges for a result, then compares it with the scoreboard head.
  task automatic check_rsp(input string name);
    exp_t e;
    for (int k = 0; k < 3 && rsp_valid !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    if (rsp_valid !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: rsp_valid=%b, expected 1", name, rsp_valid);
    end else if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: result 0x%08h with nothing expected", name, rsp_data);
    end else begin
      e = sb.pop_front();
      chk({name, "_data"}, rsp_data, e.data);
      chk({name, "_id"}, 32'(rsp_id), 32'(e.id));
    end
  endtask

  task automatic do_req(input string name, input int r, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op, input logic [31:0] exp);
    @(negedge clk);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    set_req(r, a, b, op);
    rsp_ready = 1'b1;
    #1;
    chk({name, "_ready"}, 32'(req_ready), 32'(1 << r));
    sb.push_back('{data: exp, id: 2'(r)});
    @(posedge clk);
    #1;
    req_valid = '0;
    check_rsp(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 32'd5,          32'd3,          4'd0,  32'd8};
    tbl[1]  = '{1, 32'd10,         32'd3,          4'd1,  32'd7};
    tbl[2]  = '{2, 32'd6,          32'd7,          4'd2,  32'd42};
    tbl[3]  = '{3, 32'h0001_0000,  32'h0001_0000,  4'd2,  32'd0};
    tbl[4]  = '{0, 32'd1,          32'd32,         4'd3,  32'd0};
    tbl[5]  = '{1, 32'd1,          32'd4,          4'd3,  32'd16};
    tbl[6]  = '{2, 32'h8000_0000,  32'd31,         4'd4,  32'd1};
    tbl[7]  = '{3, 32'hF0F0_F0F0,  32'hFF00_FF00,  4'd5,  32'hF000_F000};
    tbl[8]  = '{0, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  4'd6,  32'hFFFF_FFFF};
    tbl[9]  = '{1, 32'd0,          32'h1234_5678,  4'd7,  32'hFFFF_FFFF};
    tbl[10] = '{2, 32'h0000_00FF,  32'h0000_000F,  4'd8,  32'h0000_00F0};
    tbl[11] = '{3, 32'd99,         32'd1,          4'd12, 32'd0};
    tbl[12] = '{0, 32'hFFFF_FFFF,  32'd1,          4'd0,  32'd0};
    tbl[13] = '{1, 32'd0,          32'd1,          4'd1,  32'hFFFF_FFFF};

    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    #12;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    do_req("add_first", 0, 32'd5, 32'd3, 4'd0, 32'd8);
    @(posedge clk);
    #1;
    chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    foreach (tbl[i]) begin
      do_req($sformatf("vec%0d", i), tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
    end

    // Round-robin stream from a fresh pointer.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 32'd10, 32'(i), 4'd1);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("rr%0d_ready", c), 32'(req_ready), 32'(1 << (c % N)));
      sb.push_back('{data: 32'(10 - (c % N)), id: 2'(c % N)});
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_valid", c), 32'(rsp_valid), 32'd1);
      check_rsp($sformatf("rr%0d", c));
    end
    req_valid = '0;

    // Backpressure while holding the AND result.
    do_req("bp_and", 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5, 32'hF000_F000);
    rsp_ready    = 1'b0;
    set_req(2, 32'd1, 32'd2, 4'd0);
    req_valid[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d_data", c), rsp_data, 32'hF000_F000);
      chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0100);
    sb.push_back('{data: 32'd3, id: 2'd2});
    @(posedge clk);
    #1;
    req_valid = '0;
    check_rsp("bp_next");

`ifdef FU_SCHED_MULT_2CYC_EN
    @(negedge clk);
    set_req(2, 32'd6, 32'd7, 4'd2);
    req_valid = 4'b0100;
    #1;
    chk("mul_accept_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1;
    set_req(3, 32'd1, 32'd1, 4'd0);
    req_valid = 4'b1000;
    chk("mul_state_valid", 32'(rsp_valid), 32'd0);
    chk("mul_state_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("mul_holdoff_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mul_valid", 32'(rsp_valid), 32'd1);
    chk("mul_data", rsp_data, 32'd42);
    chk("mul_id", 32'(rsp_id), 32'd2);
    @(negedge clk);
    chk("mul_next_ready", 32'(req_ready), 32'b1000);
    sb.push_back('{data: 32'd2, id: 2'd3});
    @(posedge clk);
    #1;
    req_valid = '0;
    check_rsp("mul_next");
`endif

    // Asynchronous reset while FULL and stalled.
    do_req("pre_rst", 0, 32'h0000_00FF, 32'h0000_000F, 4'd8, 32'h0000_00F0);
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rsp_data", rsp_data, 32'd0);
    for (int i = 0; i < N; i++) set_req(i, 32'(i), 32'd0, 4'd0);
    req_valid = '1;
    @(negedge clk);
    chk("arst_hold_ready", 32'(req_ready), 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("arst_first_grant", 32'(req_ready), 32'b0001);
    sb.push_back('{data: 32'd0, id: 2'd0});
    @(posedge clk);
    #1;
    req_valid = '0;
    check_rsp("arst_first");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
